// File: rtl/noc_switch_alloc_if.sv
// Bundle of the 5-port switch-allocator link signals.
// Port order everywhere: N=0, S=1, E=2, W=3, L=4.
//
// Handshakes:
//  - Input side: a buffer head is offered while mask_*_i=1. It is consumed
//    on the rising edge where pop_req_*_o=1. pop_req is combinational and is
//    only raised for a head that is offered.
//  - Output side: a flit transfers on a rising edge where valid_*_o=1 and
//    ready_*_i=1. While valid=1 and ready=0, the flit and valid are held
//    stable.
interface noc_switch_alloc_if;
  logic [15:0] north_q_i, south_q_i, east_q_i, west_q_i, local_q_i;
  logic        mask_n_i, mask_s_i, mask_e_i, mask_w_i, mask_l_i;
  logic        pop_req_n_o, pop_req_s_o, pop_req_e_o, pop_req_w_o, pop_req_l_o;
  logic [15:0] north_o, south_o, east_o, west_o, local_o;
  logic        valid_n_o, valid_s_o, valid_e_o, valid_w_o, valid_l_o;
  logic        ready_n_i, ready_s_i, ready_e_i, ready_w_i, ready_l_i;

  // Switch-allocator side
  modport master (
    input  north_q_i, south_q_i, east_q_i, west_q_i, local_q_i,
    input  mask_n_i, mask_s_i, mask_e_i, mask_w_i, mask_l_i,
    output pop_req_n_o, pop_req_s_o, pop_req_e_o, pop_req_w_o, pop_req_l_o,
    output north_o, south_o, east_o, west_o, local_o,
    output valid_n_o, valid_s_o, valid_e_o, valid_w_o, valid_l_o,
    input  ready_n_i, ready_s_i, ready_e_i, ready_w_i, ready_l_i
  );

  // Buffer / downstream-link side
  modport slave (
    output north_q_i, south_q_i, east_q_i, west_q_i, local_q_i,
    output mask_n_i, mask_s_i, mask_e_i, mask_w_i, mask_l_i,
    input  pop_req_n_o, pop_req_s_o, pop_req_e_o, pop_req_w_o, pop_req_l_o,
    input  north_o, south_o, east_o, west_o, local_o,
    input  valid_n_o, valid_s_o, valid_e_o, valid_w_o, valid_l_o,
    output ready_n_i, ready_s_i, ready_e_i, ready_w_i, ready_l_i
  );
endinterface

// File: rtl/noc_switch_alloc.sv
// XY-routing switch allocator: per-output round-robin arbitration over the
// five buffer heads, with one registered flit slot per output link.
module noc_switch_alloc #(
  parameter int X_ID = 1,
  parameter int Y_ID = 1
) (
  input  logic                 clk,
  input  logic                 rst,   // asynchronous, active low
  noc_switch_alloc_if.master   sw
);

  localparam logic [2:0] XC = 3'(X_ID);
  localparam logic [2:0] YC = 3'(Y_ID);

  localparam logic [2:0] DIR_N = 3'd0;
  localparam logic [2:0] DIR_S = 3'd1;
  localparam logic [2:0] DIR_E = 3'd2;
  localparam logic [2:0] DIR_W = 3'd3;
  localparam logic [2:0] DIR_L = 3'd4;

  logic [15:0] head [5];
  logic [4:0]  mask;
  logic [4:0]  ready;

  assign head[0] = sw.north_q_i;
  assign head[1] = sw.south_q_i;
  assign head[2] = sw.east_q_i;
  assign head[3] = sw.west_q_i;
  assign head[4] = sw.local_q_i;
  assign mask    = {sw.mask_l_i, sw.mask_w_i, sw.mask_e_i, sw.mask_s_i, sw.mask_n_i};
  assign ready   = {sw.ready_l_i, sw.ready_w_i, sw.ready_e_i, sw.ready_s_i, sw.ready_n_i};

  logic [15:0] data_q  [5];
  logic [15:0] data_d  [5];
  logic [4:0]  valid_q, valid_d;
  logic [2:0]  ptr_q   [5];
  logic [2:0]  ptr_d   [5];

  logic [2:0]  dir   [5];
  logic [4:0]  req   [5];   // req[o][i]: input i wants output o
  logic [4:0]  grant [5];   // grant[o][i]
  logic [2:0]  win   [5];
  logic [4:0]  can_acc;
  logic [4:0]  pop;

  // XY route compute for each head flit (X first, then Y, else local)
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      if (head[i][15:13] > XC)      dir[i] = DIR_E;
      else if (head[i][15:13] < XC) dir[i] = DIR_W;
      else if (head[i][12:10] > YC) dir[i] = DIR_N;
      else if (head[i][12:10] < YC) dir[i] = DIR_S;
      else                          dir[i] = DIR_L;
    end
  end

  // Request matrix: only offered heads request their routed output
  always_comb begin
    for (int o = 0; o < 5; o++) begin
      req[o] = '0;
      for (int i = 0; i < 5; i++) begin
        req[o][i] = mask[i] && (dir[i] == 3'(o));
      end
    end
  end

  // Round-robin arbitration per output, gated by slot availability
  always_comb begin
    for (int o = 0; o < 5; o++) begin
      logic       found;
      logic [3:0] sum;
      logic [2:0] idx;
      grant[o]   = '0;
      win[o]     = '0;
      found      = 1'b0;
      sum        = '0;
      idx        = '0;
      can_acc[o] = !valid_q[o] || ready[o];
      for (int k = 0; k < 5; k++) begin
        sum = {1'b0, ptr_q[o]} + 4'(k);
        if (sum >= 4'd5) sum = sum - 4'd5;
        idx = sum[2:0];
        if (!found && can_acc[o] && req[o][idx]) begin
          grant[o][idx] = 1'b1;
          win[o]        = idx;
          found         = 1'b1;
        end
      end
    end
  end

  // Pop whichever inputs won any output; never pop while in reset
  always_comb begin
    pop = '0;
    for (int o = 0; o < 5; o++) begin
      pop = pop | grant[o];
    end
    if (!rst) pop = '0;
  end

  // Output slot update: load on grant, drain on ready, otherwise hold
  always_comb begin
    for (int o = 0; o < 5; o++) begin
      data_d[o]  = data_q[o];
      valid_d[o] = valid_q[o];
      ptr_d[o]   = ptr_q[o];
      if (|grant[o]) begin
        data_d[o]  = head[win[o]];
        valid_d[o] = 1'b1;
        ptr_d[o]   = (win[o] == 3'd4) ? 3'd0 : win[o] + 3'd1;
      end else if (ready[o]) begin
        valid_d[o] = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int o = 0; o < 5; o++) begin
        data_q[o] <= '0;
        ptr_q[o]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int o = 0; o < 5; o++) begin
        data_q[o] <= data_d[o];
        ptr_q[o]  <= ptr_d[o];
      end
    end
  end

  assign sw.pop_req_n_o = pop[0];
  assign sw.pop_req_s_o = pop[1];
  assign sw.pop_req_e_o = pop[2];
  assign sw.pop_req_w_o = pop[3];
  assign sw.pop_req_l_o = pop[4];

  assign sw.north_o = data_q[0];
  assign sw.south_o = data_q[1];
  assign sw.east_o  = data_q[2];
  assign sw.west_o  = data_q[3];
  assign sw.local_o = data_q[4];

  assign sw.valid_n_o = valid_q[0];
  assign sw.valid_s_o = valid_q[1];
  assign sw.valid_e_o = valid_q[2];
  assign sw.valid_w_o = valid_q[3];
  assign sw.valid_l_o = valid_q[4];

endmodule

// File: doc/noc_switch_alloc.md
Name: noc_switch_alloc

Overview:
- Router stage directly downstream of the 5-port input buffer block (N, S, E, W, L).
- Examines each buffer's head flit and computes the output direction with XY routing.
- Arbitrates per output with round-robin priority and pops winning heads via pop_req_*.
- Registers winning flits onto the five output links, with per-link valid/ready flow control.

Parameters:
- X_ID, 1, router x coordinate (3 bits used).
- Y_ID, 1, router y coordinate (3 bits used).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- north_q_i / south_q_i / east_q_i / west_q_i / local_q_i  input  16 each  buffer head flits.
- mask_n_i / mask_s_i / mask_e_i / mask_w_i / mask_l_i  input  1 each  buffer non-empty; head flit valid.
- pop_req_n_o / pop_req_s_o / pop_req_e_o / pop_req_w_o / pop_req_l_o  output  1 each  pop buffer head this cycle (combinational).
- north_o / south_o / east_o / west_o / local_o  output  16 each  registered output-link flits.
- valid_n_o / valid_s_o / valid_e_o / valid_w_o / valid_l_o  output  1 each  output-link flit valid.
- ready_n_i / ready_s_i / ready_e_i / ready_w_i / ready_l_i  input  1 each  downstream accepts flit this cycle.

Behaviour:
- Index order: N=0, S=1, E=2, W=3, L=4.
- Flit format: [15:13] dest_x, [12:10] dest_y, [9:0] payload. All packets are single-flit.
- Route compute (combinational, per input):
  - dest_x > X_ID -> E; dest_x < X_ID -> W.
  - Else dest_y > Y_ID -> N; dest_y < Y_ID -> S.
  - Else -> L.
  - No U-turn suppression. Unsigned compares.
- Request: input i requests output d only when mask_i=1. Each input requests at most one output, so no input can win twice.
- Output slot o can accept a flit when valid_o=0, or when valid_o=1 and ready_o=1.
- Arbitration per output o:
  - Among the requesting inputs, scan from ptr_o upward, mod 5. The first requester wins.
  - A grant is issued only if slot o can accept.
  - Grant to input i drives pop_req_i=1 in the same cycle.
- Grant edge (rising clk):
  - Output o data <= head of input i; valid_o <= 1.
  - ptr_o <= (i+1) mod 5. Wrap: winner 4 -> ptr 0.
- No-grant edge:
  - If ready_o=1, valid_o <= 0.
  - Data holds while valid_o=1 and ready_o=0.
  - ptr_o is unchanged.
- Simultaneous drain and grant on the same edge: the new flit replaces the old, valid stays 1. This sustains full throughput of one flit per cycle per output.
- Latency: head visible at cycle t -> pop_req at t -> output valid at t+1.
- Backpressure: while ready_o=0 and valid_o=1, no grant is issued for o, and requesters of o see pop_req=0.
- mask_i=0: pop_req_i=0 regardless of the head value.
- Reset (rst=0, async):
  - All valid_*_o=0, all data outputs 16'h0000, all ptr=0.
  - pop_req_*_o=0 while rst=0.
- Reset mid-operation: in-flight registered flits are discarded. Buffers are not popped during reset.
- Outputs are independent: up to 5 grants in one cycle.

Test Plan:
- Reset: rst=0 with mask_*=1 -> all pop_req=0, valid_*_o=0, data 16'h0000. After release, first grants start from ptr=0.
- Single route: X_ID=1, Y_ID=1, north_q_i=16'h4405 (dest 2,1), mask_n=1, ready_e=1 -> pop_req_n=1 same cycle, east_o=16'h4405 with valid_e=1 next cycle.
- Round-robin: N, S and L all hold 16'h2400 (dest 1,1 -> L), masks held 1, ready_l=1 -> winners N, S, L, N on consecutive cycles. pop_req follows the same order.
- Backpressure: valid_w=1, ready_w=0 for 3 cycles while E requests W -> west_o held, pop_req_e=0. Then ready_w=1 -> drain and new grant on the same edge, valid_w stays 1.
- Parallel grants: N->S, S->N, E->W, W->E, L->L all requesting, all ready=1 -> five pop_req=1 in one cycle, all five valids next cycle.
- Async reset mid-stream: assert rst=0 between edges while valids are set -> valids drop immediately without a clock edge, and no pop occurs.
